// File: rtl/multicycle_control_unit_pkg.sv
// Shared control definitions for the multi-cycle RV32I core: opcodes, FSM states,
// ALU_Op codes and datapath select codes.
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_LUI       = 4'd9,
    S_ALU_WB    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JAL       = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  localparam logic [2:0] ALU_OP_R   = 3'b000;
  localparam logic [2:0] ALU_OP_I   = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_R,
    CLS_I,
    CLS_BRANCH,
    CLS_JAL,
    CLS_LUI,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/multicycle_control_unit_main_opcode_decoder.sv
// Combinational opcode classifier selecting the state that follows DECODE.
module main_opcode_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  op_class_o
);

  always_comb begin
    op_class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_LOAD, OP_STORE: op_class_o = CLS_MEM;
      OP_RTYPE:          op_class_o = CLS_R;
      OP_ITYPE:          op_class_o = CLS_I;
      OP_BRANCH:         op_class_o = CLS_BRANCH;
      OP_JAL:            op_class_o = CLS_JAL;
      OP_LUI:            op_class_o = CLS_LUI;
      default:           op_class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences memory, register file and ALU per
// instruction, waits on mem_ready_i and traps on unsupported opcodes.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PC_Write_o,
  output logic       IR_Write_o,
  output logic       IorD_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Reg_Write_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic [1:0] Result_Src_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e    state_q, state_d;
  op_class_e op_class;

  main_opcode_decoder u_main_opcode_decoder (
    .opcode_i   (opcode_i),
    .op_class_o (op_class)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d      = S_IDLE;
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    IorD_o       = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Reg_Write_o  = 1'b0;
    ALU_Src_A_o  = SRC_A_PC;
    ALU_Src_B_o  = SRC_B_RS2;
    ALU_Op_o     = ALU_OP_R;
    Result_Src_o = RES_ALUOUT;
    illegal_o    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 goes straight from the ALU into PC on the same edge the IR loads
      S_FETCH: begin
        Mem_Read_o   = 1'b1;
        ALU_Src_B_o  = SRC_B_FOUR;
        ALU_Op_o     = ALU_OP_ADD;
        Result_Src_o = RES_ALU;
        IR_Write_o   = mem_ready_i;
        PC_Write_o   = mem_ready_i;
        state_d      = mem_ready_i ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        ALU_Src_A_o = SRC_A_OLDPC;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_ADD;
        case (op_class)
          CLS_MEM:    state_d = S_MEM_ADDR;
          CLS_R:      state_d = S_EXEC_R;
          CLS_I:      state_d = S_EXEC_I;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JAL:    state_d = S_JAL;
          CLS_LUI:    state_d = S_LUI;
          default:    state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_ADD;
        state_d     = (opcode_i == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        IorD_o     = 1'b1;
        Mem_Read_o = 1'b1;
        state_d    = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      end

      S_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Result_Src_o = RES_MDR;
        state_d      = S_FETCH;
      end

      S_MEM_WRITE: begin
        IorD_o      = 1'b1;
        Mem_Write_o = 1'b1;
        state_d     = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      end

      S_EXEC_R: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_RS2;
        ALU_Op_o    = ALU_OP_R;
        state_d     = S_ALU_WB;
      end

      S_EXEC_I: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_I;
        state_d     = S_ALU_WB;
      end

      S_LUI: begin
        ALU_Src_A_o = SRC_A_ZERO;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o    = ALU_OP_ADD;
        state_d     = S_ALU_WB;
      end

      S_ALU_WB: begin
        Reg_Write_o  = 1'b1;
        Result_Src_o = RES_ALUOUT;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        ALU_Src_A_o  = SRC_A_RS1;
        ALU_Src_B_o  = SRC_B_RS2;
        ALU_Op_o     = ALU_OP_SUB;
        Result_Src_o = RES_ALUOUT;
        PC_Write_o   = zero_i;
        state_d      = S_FETCH;
      end

      // PC takes the target from ALUOut while the ALU forms oldPC+4 for rd
      S_JAL: begin
        PC_Write_o   = 1'b1;
        Result_Src_o = RES_ALUOUT;
        ALU_Src_A_o  = SRC_A_OLDPC;
        ALU_Src_B_o  = SRC_B_FOUR;
        ALU_Op_o     = ALU_OP_ADD;
        state_d      = S_ALU_WB;
      end

      S_TRAP: begin
        illegal_o = 1'b1;
        state_d   = S_TRAP;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
